// File: rtl/tff_bank_counter_if.sv
// Control and status bundle for tff_bank_counter.
// The master drives enable, mode and data. The slave returns state and flags.
interface tff_bank_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;

    modport master (output en, mode, t, d, input q, tc, ovf);
    modport slave  (input en, mode, t, d, output q, tc, ovf);
endinterface

// File: rtl/tff_bank_counter.sv
// WIDTH-bit toggle bank that doubles as a modulo-MODULUS up/down counter with load.
// It provides a combinational terminal-count flag and a registered wrap/saturate pulse.
module tff_bank_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input logic               clk,
    input logic               rst,
    tff_bank_counter_if.slave bus
);

    localparam logic [1:0] MODE_TOGGLE = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;

    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("tff_bank_counter: MODULUS must lie in 2..2**WIDTH");
    end

    // Each step function returns {boundary_hit, next_q}.
    function automatic logic [WIDTH:0] up_step(input logic [WIDTH-1:0] cur);
        if (cur < Q_MAX) return {1'b0, cur + WIDTH'(1)};
        return {1'b1, (SATURATE != 0) ? Q_MAX : {WIDTH{1'b0}}};
    endfunction

    function automatic logic [WIDTH:0] down_step(input logic [WIDTH-1:0] cur);
        if (cur == '0) return {1'b1, (SATURATE != 0) ? {WIDTH{1'b0}} : Q_MAX};
        // An out-of-range value left by toggle mode re-enters at the top without a pulse.
        if ({1'b0, cur} >= MOD_EXT) return {1'b0, Q_MAX};
        return {1'b0, cur - WIDTH'(1)};
    endfunction

    function automatic logic [WIDTH-1:0] load_clamp(input logic [WIDTH-1:0] val);
        return ({1'b0, val} >= MOD_EXT) ? Q_MAX : val;
    endfunction

    logic [WIDTH-1:0] q_p1;
    logic             ovf_p1;
    logic [WIDTH:0]   nxt;

    always_comb begin
        nxt = {1'b0, q_p1};
        case (bus.mode)
            MODE_TOGGLE: nxt = {1'b0, q_p1 ^ bus.t};
            MODE_UP:     nxt = up_step(q_p1);
            MODE_DOWN:   nxt = down_step(q_p1);
            default:     nxt = {1'b0, load_clamp(bus.d)};
        endcase
    end

    // Register stage: state and boundary pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_p1   <= '0;
            ovf_p1 <= 1'b0;
        end else if (!bus.en) begin
            ovf_p1 <= 1'b0;
        end else begin
            q_p1   <= nxt[WIDTH-1:0];
            ovf_p1 <= nxt[WIDTH];
        end
    end

    assign bus.q   = q_p1;
    assign bus.ovf = ovf_p1;
    assign bus.tc  = bus.en & (((bus.mode == MODE_UP) & (q_p1 >= Q_MAX)) |
                               ((bus.mode == MODE_DOWN) & (q_p1 == '0)));

endmodule

// File: tb/tb_tff_bank_counter.sv
// Bench for tff_bank_counter: one wrapping and one saturating instance (MODULUS=10) driven in lockstep.
// It checks them against a vector table and a scoreboard queue.
module tb_tff_bank_counter;
    localparam int W = 4;
    localparam logic [1:0] TG = 2'b00;
    localparam logic [1:0] UP = 2'b01;
    localparam logic [1:0] DN = 2'b10;
    localparam logic [1:0] LD = 2'b11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tff_bank_counter_if #(.WIDTH(W)) bus_w ();
    tff_bank_counter_if #(.WIDTH(W)) bus_s ();

    tff_bank_counter #(.WIDTH(W), .MODULUS(10), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w.slave));
    tff_bank_counter #(.WIDTH(W), .MODULUS(10), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.slave));

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [3:0] t;
        logic [3:0] d;
        logic       tc_w;
        logic [3:0] q_w;
        logic       ovf_w;
        logic       tc_s;
        logic [3:0] q_s;
        logic       ovf_s;
    } vec_t;

    typedef struct {
        logic [3:0] q_w;
        logic       ovf_w;
        logic [3:0] q_s;
        logic       ovf_s;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[29];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic [3:0] tt, input logic [3:0] dd,
                                input logic tcw, input logic [3:0] qw, input logic ow,
                                input logic tcs, input logic [3:0] qs, input logic os);
        vec_t v;
        v.rst = r;  v.en = e;  v.mode = m;  v.t = tt;  v.d = dd;
        v.tc_w = tcw;  v.q_w = qw;  v.ovf_w = ow;
        v.tc_s = tcs;  v.q_s = qs;  v.ovf_s = os;
        return v;
    endfunction

    task automatic check4(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check1(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0b expected %0b", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        rst        = v.rst;
        bus_w.en   = v.en;   bus_s.en   = v.en;
        bus_w.mode = v.mode; bus_s.mode = v.mode;
        bus_w.t    = v.t;    bus_s.t    = v.t;
        bus_w.d    = v.d;    bus_s.d    = v.d;
        #1;
        check1("tc_wrap", idx, bus_w.tc, v.tc_w);
        check1("tc_sat", idx, bus_s.tc, v.tc_s);
        sb.push_back('{q_w: v.q_w, ovf_w: v.ovf_w, q_s: v.q_s, ovf_s: v.ovf_s});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step %0d: got empty queue expected one entry", idx);
        end else begin
            e = sb.pop_front();
            check4("q_wrap", idx, bus_w.q, e.q_w);
            check1("ovf_wrap", idx, bus_w.ovf, e.ovf_w);
            check4("q_sat", idx, bus_s.q, e.q_s);
            check1("ovf_sat", idx, bus_s.ovf, e.ovf_s);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        bus_w.en = 1'b0; bus_s.en = 1'b0;
        bus_w.mode = TG; bus_s.mode = TG;
        bus_w.t = '0;    bus_s.t = '0;
        bus_w.d = '0;    bus_s.d = '0;

        //             rst   en    mode t      d      tcw   qw     ow    tcs   qs     os
        vecs[0]  = mk(1'b1, 1'b0, TG, 4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0);
        vecs[1]  = mk(1'b1, 1'b1, TG, 4'd10, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0);
        vecs[2]  = mk(1'b0, 1'b1, TG, 4'd10, 4'd0,  1'b0, 4'd10, 1'b0, 1'b0, 4'd10, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, TG, 4'd10, 4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0);
        vecs[4]  = mk(1'b0, 1'b1, TG, 4'd10, 4'd0,  1'b0, 4'd10, 1'b0, 1'b0, 4'd10, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, TG, 4'd0,  4'd0,  1'b0, 4'd10, 1'b0, 1'b0, 4'd10, 1'b0);
        vecs[6]  = mk(1'b0, 1'b1, LD, 4'd0,  4'd7,  1'b0, 4'd7,  1'b0, 1'b0, 4'd7,  1'b0);
        vecs[7]  = mk(1'b0, 1'b1, UP, 4'd0,  4'd0,  1'b0, 4'd8,  1'b0, 1'b0, 4'd8,  1'b0);
        vecs[8]  = mk(1'b0, 1'b1, UP, 4'd0,  4'd0,  1'b0, 4'd9,  1'b0, 1'b0, 4'd9,  1'b0);
        vecs[9]  = mk(1'b0, 1'b1, UP, 4'd0,  4'd0,  1'b1, 4'd0,  1'b1, 1'b1, 4'd9,  1'b1);
        vecs[10] = mk(1'b0, 1'b1, UP, 4'd0,  4'd0,  1'b0, 4'd1,  1'b0, 1'b1, 4'd9,  1'b1);
        vecs[11] = mk(1'b0, 1'b1, LD, 4'd0,  4'd1,  1'b0, 4'd1,  1'b0, 1'b0, 4'd1,  1'b0);
        vecs[12] = mk(1'b0, 1'b1, DN, 4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0);
        vecs[13] = mk(1'b0, 1'b1, DN, 4'd0,  4'd0,  1'b1, 4'd9,  1'b1, 1'b1, 4'd0,  1'b1);
        vecs[14] = mk(1'b0, 1'b1, DN, 4'd0,  4'd0,  1'b0, 4'd8,  1'b0, 1'b1, 4'd0,  1'b1);
        vecs[15] = mk(1'b0, 1'b1, DN, 4'd0,  4'd0,  1'b0, 4'd7,  1'b0, 1'b1, 4'd0,  1'b1);
        vecs[16] = mk(1'b0, 1'b1, LD, 4'd0,  4'd13, 1'b0, 4'd9,  1'b0, 1'b0, 4'd9,  1'b0);
        vecs[17] = mk(1'b0, 1'b1, TG, 4'd6,  4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0);
        vecs[18] = mk(1'b0, 1'b1, UP, 4'd0,  4'd0,  1'b1, 4'd0,  1'b1, 1'b1, 4'd9,  1'b1);
        vecs[19] = mk(1'b0, 1'b1, LD, 4'd0,  4'd9,  1'b0, 4'd9,  1'b0, 1'b0, 4'd9,  1'b0);
        vecs[20] = mk(1'b0, 1'b1, TG, 4'd6,  4'd0,  1'b0, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0);
        vecs[21] = mk(1'b0, 1'b1, DN, 4'd0,  4'd0,  1'b0, 4'd9,  1'b0, 1'b0, 4'd9,  1'b0);
        vecs[22] = mk(1'b0, 1'b1, LD, 4'd0,  4'd5,  1'b0, 4'd5,  1'b0, 1'b0, 4'd5,  1'b0);
        vecs[23] = mk(1'b0, 1'b0, UP, 4'd0,  4'd0,  1'b0, 4'd5,  1'b0, 1'b0, 4'd5,  1'b0);
        vecs[24] = mk(1'b0, 1'b0, UP, 4'd0,  4'd0,  1'b0, 4'd5,  1'b0, 1'b0, 4'd5,  1'b0);
        vecs[25] = mk(1'b0, 1'b0, UP, 4'd0,  4'd0,  1'b0, 4'd5,  1'b0, 1'b0, 4'd5,  1'b0);
        vecs[26] = mk(1'b1, 1'b1, UP, 4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 4'd0,  1'b0);
        vecs[27] = mk(1'b0, 1'b1, UP, 4'd0,  4'd0,  1'b0, 4'd1,  1'b0, 1'b0, 4'd1,  1'b0);
        vecs[28] = mk(1'b0, 1'b1, UP, 4'd0,  4'd0,  1'b0, 4'd2,  1'b0, 1'b0, 4'd2,  1'b0);

        for (int i = 0; i < 29; i++) apply(vecs[i], i);

        // Pinned at the top: the saturating instance re-pulses ovf on every step.
        apply(mk(1'b0, 1'b1, LD, 4'd0, 4'd9, 1'b0, 4'd9, 1'b0, 1'b0, 4'd9, 1'b0), 100);
        for (int k = 0; k < 3; k++) begin
            apply(mk(1'b0, 1'b1, UP, 4'd0, 4'd0,
                     (k == 0), 4'(k), (k == 0),
                     1'b1, 4'd9, 1'b1), 101 + k);
        end
        // Dropping enable while pinned clears ovf and holds q.
        apply(mk(1'b0, 1'b0, UP, 4'd0, 4'd0, 1'b0, 4'd2, 1'b0, 1'b0, 4'd9, 1'b0), 104);

        // Underflow pulse lasts exactly one cycle when counting resumes.
        apply(mk(1'b0, 1'b1, LD, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0), 105);
        apply(mk(1'b0, 1'b1, DN, 4'd0, 4'd0, 1'b1, 4'd9, 1'b1, 1'b1, 4'd0, 1'b1), 106);
        apply(mk(1'b0, 1'b1, TG, 4'd1, 4'd0, 1'b0, 4'd8, 1'b0, 1'b0, 4'd1, 1'b0), 107);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
